// File: rtl/lstm_gate_seq.sv
// lstm_gate_seq: sequential evaluation of one LSTM gate value.
// Computes act( sum_i x[i]*w[i] + sum_j h[j]*u[j] + b ) with a single shared
// fixed-point multiplier. The result is a saturating WIDTH-bit accumulation,
// and the activation is a piecewise-linear sigmoid or a clamped tanh.
module lstm_gate_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 20,
    parameter int NX    = 4,
    parameter int NH    = 4,
    localparam int NMAX = (NX > NH) ? NX : NH,
    localparam int IDXW = (NMAX > 1) ? $clog2(NMAX) : 1
) (
    input  logic             clk,
    input  logic             rst,        // asynchronous, active-low
    input  logic             i_start,
    input  logic             i_act_sel,  // 0 = sigmoid, 1 = tanh
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_w,
    input  logic [WIDTH-1:0] i_h,
    input  logic [WIDTH-1:0] i_u,
    input  logic [WIDTH-1:0] i_b,
    output logic [IDXW-1:0]  o_idx,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_act
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC_X,
        S_MAC_H,
        S_BIAS,
        S_DONE
    } state_t;

    // Saturation limits, sign-extended to the width of the wide adder.
    localparam logic signed [2*WIDTH:0] SAT_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH:0] SAT_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    // Fixed-point 1.0, 0.5 and -1.0 with one guard bit for the activation clamp.
    localparam logic signed [WIDTH:0] ONE_X     = {{WIDTH{1'b0}}, 1'b1} << FRAC;
    localparam logic signed [WIDTH:0] HALF_X    = ONE_X >>> 1;
    localparam logic signed [WIDTH:0] NEG_ONE_X = -ONE_X;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              mode_q, mode_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  act_q, act_d;
    logic              valid_q, valid_d;

    logic [WIDTH-1:0]          mul_a, mul_b;
    logic signed [2*WIDTH-1:0] mul_a_ext, mul_b_ext;
    logic signed [2*WIDTH-1:0] prod_full, prod_shift, addend;
    logic signed [2*WIDTH:0]   sum_wide;
    logic [WIDTH-1:0]          sat_sum;

    logic signed [WIDTH-1:0]   sum_s, sum_quarter;
    logic signed [WIDTH:0]     act_src, act_lo;
    logic [WIDTH-1:0]          act_sat;

    // Operand mux: x/w pair during MAC_X, h/u pair during MAC_H.
    always_comb begin
        mul_a = i_x;
        mul_b = i_w;
        if (state_q == S_MAC_H) begin
            mul_a = i_h;
            mul_b = i_u;
        end
    end

    // Full-precision signed product, floored back to FRAC fractional bits.
    assign mul_a_ext  = {{WIDTH{mul_a[WIDTH-1]}}, mul_a};
    assign mul_b_ext  = {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
    assign prod_full  = mul_a_ext * mul_b_ext;
    assign prod_shift = prod_full >>> FRAC;

    // The bias uses the same saturating adder as the products.
    assign addend   = (state_q == S_BIAS) ? {{WIDTH{i_b[WIDTH-1]}}, i_b} : prod_shift;
    assign sum_wide = {{(WIDTH+1){acc_q[WIDTH-1]}}, acc_q} + {addend[2*WIDTH-1], addend};

    // Clamp the wide sum to the WIDTH range so the accumulator never wraps.
    always_comb begin
        sat_sum = sum_wide[WIDTH-1:0];
        if (sum_wide > SAT_MAX) begin
            sat_sum = SAT_MAX[WIDTH-1:0];
        end else if (sum_wide < SAT_MIN) begin
            sat_sum = SAT_MIN[WIDTH-1:0];
        end
    end

    // Activation from the registered pre-activation sum:
    // sigmoid ~ clamp(s/4 + 0.5, 0, 1), tanh ~ clamp(s, -1, 1).
    assign sum_s       = $signed(sum_q);
    assign sum_quarter = sum_s >>> 2;
    always_comb begin
        act_src = {sum_quarter[WIDTH-1], sum_quarter} + HALF_X;
        act_lo  = '0;
        if (mode_q) begin
            act_src = {sum_s[WIDTH-1], sum_s};
            act_lo  = NEG_ONE_X;
        end
        act_sat = act_src[WIDTH-1:0];
        if (act_src > ONE_X) begin
            act_sat = ONE_X[WIDTH-1:0];
        end else if (act_src < act_lo) begin
            act_sat = act_lo[WIDTH-1:0];
        end
    end

    // Next-state logic; i_start and i_act_sel only matter in IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        acc_d   = acc_q;
        mode_d  = mode_q;
        sum_d   = sum_q;
        act_d   = act_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_MAC_X;
                    acc_d   = '0;
                    mode_d  = i_act_sel;
                end
            end
            S_MAC_X: begin
                acc_d = sat_sum;
                if (idx_q == IDXW'(NX - 1)) begin
                    state_d = S_MAC_H;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_MAC_H: begin
                acc_d = sat_sum;
                if (idx_q == IDXW'(NH - 1)) begin
                    state_d = S_BIAS;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_BIAS: begin
                acc_d   = sat_sum;
                sum_d   = sat_sum;
                state_d = S_DONE;
            end
            S_DONE: begin
                // Result and valid pulse are registered on the edge that closes DONE.
                act_d   = act_sat;
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            mode_q  <= 1'b0;
            sum_q   <= '0;
            act_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mode_q  <= mode_d;
            sum_q   <= sum_d;
            act_q   <= act_d;
            valid_q <= valid_d;
        end
    end

    assign o_idx   = idx_q;
    assign o_busy  = (state_q == S_MAC_X) || (state_q == S_MAC_H) || (state_q == S_BIAS);
    assign o_valid = valid_q;
    assign o_sum   = sum_q;
    assign o_act   = act_q;

endmodule

// File: tb/tb_lstm_gate_seq.sv
// Testbench for lstm_gate_seq (WIDTH=32, FRAC=20, NX=NH=2).
// Table-driven gate computations with a scoreboard, plus hand-written
// sequences for busy/index timing, back-to-back starts and mid-run reset.
module tb_lstm_gate_seq;

    localparam int W    = 32;
    localparam int FRAC = 20;
    localparam int NX   = 2;
    localparam int NH   = 2;
    localparam int LAT  = NX + NH + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic         i_act_sel = 1'b0;
    logic [W-1:0] i_x, i_w, i_h, i_u, i_b;
    logic [0:0]   o_idx;
    logic         o_busy, o_valid;
    logic [W-1:0] o_sum, o_act;

    // Operand memories the DUT reads through o_idx.
    logic [W-1:0] cx [NX];
    logic [W-1:0] cw [NX];
    logic [W-1:0] ch [NH];
    logic [W-1:0] cu [NH];
    logic [W-1:0] cb;

    assign i_x = cx[o_idx];
    assign i_w = cw[o_idx];
    assign i_h = ch[o_idx];
    assign i_u = cu[o_idx];
    assign i_b = cb;

    lstm_gate_seq #(.WIDTH(W), .FRAC(FRAC), .NX(NX), .NH(NH)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_act_sel (i_act_sel),
        .i_x       (i_x),
        .i_w       (i_w),
        .i_h       (i_h),
        .i_u       (i_u),
        .i_b       (i_b),
        .o_idx     (o_idx),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_sum     (o_sum),
        .o_act     (o_act)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] x0, x1, w0, w1, h0, h1, u0, u1, b;
        logic         sel;
        logic [W-1:0] sum, act;
    } vec_t;

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] act;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_valid = 0;
    int   n_txn   = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] x0, x1, w0, w1, h0, h1, u0, u1, b,
                                input logic sel, input logic [W-1:0] sum, act);
        vec_t v;
        v.x0 = x0; v.x1 = x1; v.w0 = w0; v.w1 = w1;
        v.h0 = h0; v.h1 = h1; v.u0 = u0; v.u1 = u1;
        v.b = b; v.sel = sel; v.sum = sum; v.act = act;
        return v;
    endfunction

    task automatic load(input vec_t v);
        cx[0] = v.x0; cx[1] = v.x1;
        cw[0] = v.w0; cw[1] = v.w1;
        ch[0] = v.h0; ch[1] = v.h1;
        cu[0] = v.u0; cu[1] = v.u1;
        cb    = v.b;
    endtask

    // Called just after a falling edge: start on the next rising edge and
    // record the expected result and the cycle its valid pulse must appear.
    task automatic start_op(input logic sel, input logic [W-1:0] sum, input logic [W-1:0] act);
        exp_t e;
        i_start   = 1'b1;
        i_act_sel = sel;
        e.sum = sum;
        e.act = act;
        e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        i_start   = 1'b0;
        i_act_sel = ~sel;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Scoreboard consumer: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && o_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected o_valid: got sum=%h act=%h, expected no result", o_sum, o_act);
            end else begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: cycle=%0d sum=%h act=%h (exp cycle=%0d sum=%h act=%h)",
                         n_txn, cyc, o_sum, o_act, e.cyc, e.sum, e.act);
                check("o_sum", o_sum, e.sum);
                check("o_act", o_act, e.act);
                check("latency", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t tab[10];

    initial begin
        int s0;
        int v0;
        vec_t z;

        tab[0] = mk(32'h00100000, 32'h00080000, 32'h00080000, 32'h00100000, 0, 0, 0, 0, 0,
                    1'b1, 32'h00100000, 32'h00100000);
        tab[1] = mk(32'h00100000, 32'h00080000, 32'h00080000, 32'h00100000, 0, 0, 0, 0, 0,
                    1'b0, 32'h00100000, 32'h000C0000);
        tab[2] = mk(32'hFFF00000, 32'hFFE00000, 32'h00100000, 32'h00100000, 0, 0, 0, 0, 0,
                    1'b0, 32'hFFD00000, 32'h00000000);
        tab[3] = mk(32'hFFF00000, 32'hFFE00000, 32'h00100000, 32'h00100000, 0, 0, 0, 0, 0,
                    1'b1, 32'hFFD00000, 32'hFFF00000);
        tab[4] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    1'b0, 32'h7FFFFFFF, 32'h00100000);
        tab[5] = mk(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    1'b1, 32'h7FFFFFFF, 32'h00100000);
        tab[6] = mk(0, 0, 0, 0, 32'h00100000, 32'hFFF00000, 32'h00100000, 32'h00100000,
                    32'h00040000, 1'b0, 32'h00040000, 32'h00090000);
        // Floor rounding: -0.5*3.0, tiny product to 0, 1 LSB * -1 LSB to -1 LSB.
        tab[7] = mk(32'hFFF80000, 32'h00000003, 32'h00300000, 32'h00000001, 32'h00000001, 0,
                    32'hFFFFFFFF, 0, 0, 1'b0, 32'hFFE7FFFF, 32'h0001FFFF);
        // Negative saturation, bias cannot pull it further down.
        tab[8] = mk(32'h80000000, 0, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 32'h80000000,
                    1'b1, 32'h80000000, 32'hFFF00000);
        // Saturation applied per add: saturate high, then subtract 1.0.
        tab[9] = mk(32'h7FFFFFFF, 32'hFFF00000, 32'h7FFFFFFF, 32'h00100000, 0, 0, 0, 0, 0,
                    1'b1, 32'h7FEFFFFF, 32'h00100000);

        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
        load(z);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset o_busy", {31'b0, o_busy}, 32'h0);
        check("reset o_valid", {31'b0, o_valid}, 32'h0);
        check("reset o_idx", {31'b0, o_idx}, 32'h0);
        check("reset o_sum", o_sum, 32'h0);
        check("reset o_act", o_act, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            load(tab[i]);
            start_op(tab[i].sel, tab[i].sum, tab[i].act);
            drain();
        end

        // Busy and index sequencing over one operation.
        load(tab[0]);
        start_op(tab[0].sel, tab[0].sum, tab[0].act);
        for (int k = 0; k < LAT + 1; k++) begin
            check($sformatf("o_busy step %0d", k), {31'b0, o_busy}, (k < NX + NH + 1) ? 32'h1 : 32'h0);
            check($sformatf("o_idx step %0d", k), {31'b0, o_idx}, (k < NX + NH) ? (k % 2) : 0);
            @(negedge clk);
        end
        drain();

        // i_start held high: one result per LAT+1 cycles, mid-run i_act_sel ignored.
        load(tab[3]);
        v0 = n_valid;
        s0 = cyc + 1;
        i_start = 1'b1;
        for (int k = 0; k < 3 * (LAT + 1); k++) begin
            i_act_sel = ((cyc + 1 - s0) % (LAT + 1) == 0);
            if (k % (LAT + 1) == 0) begin
                exp_t e;
                e.sum = 32'hFFD00000;
                e.act = 32'hFFF00000;
                e.cyc = cyc + 1 + LAT;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        i_start   = 1'b0;
        i_act_sel = 1'b0;
        drain();
        repeat (10) @(negedge clk);
        check("back-to-back valid count", n_valid - v0, 3);

        // Reset asserted during MAC_H aborts with no result.
        load(tab[1]);
        i_start   = 1'b1;
        i_act_sel = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (2) @(negedge clk);
        check("busy before abort", {31'b0, o_busy}, 32'h1);
        rst = 1'b0;
        #1;
        check("abort o_busy", {31'b0, o_busy}, 32'h0);
        check("abort o_valid", {31'b0, o_valid}, 32'h0);
        check("abort o_idx", {31'b0, o_idx}, 32'h0);
        check("abort o_sum", o_sum, 32'h0);
        check("abort o_act", o_act, 32'h0);
        @(negedge clk);
        @(negedge clk);
        // Start on the first rising edge after release.
        rst = 1'b1;
        load(tab[0]);
        start_op(1'b1, 32'h00100000, 32'h00100000);
        check("no partial o_sum", o_sum, 32'h0);
        drain();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
